// File: rtl/mdu_ctrl_if.sv
// EXE <-> multiply/divide controller bundle: request handshake, flush, status and HI/LO.
// A request transfers on an edge where req_valid & req_ready & !flush; the master holds op/operands until then.
interface mdu_ctrl_if;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        req_ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  modport master (
    output req_valid, req_op, req_src1, req_src2, flush,
    input  req_ready, busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  req_valid, req_op, req_src1, req_src2, flush,
    output req_ready, busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/mdu_ctrl.sv
// HI/LO owner: fixed-latency multiply, 32-step restoring divide with sign fixup,
// MTHI/MTLO writes, and flush abort that leaves HI/LO untouched.
module mdu_ctrl #(
  parameter int MUL_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      r_state, w_state_nx;
  logic [4:0]  r_cnt, w_cnt_nx;
  // r_a: multiplicand, or dividend/quotient shift register during DIV
  logic [32:0] r_a, w_a_nx;
  logic [32:0] r_b, w_b_nx;
  logic [32:0] r_rem, w_rem_nx;
  logic        r_neg_q, w_neg_q_nx;
  logic        r_neg_r, w_neg_r_nx;
  logic [31:0] r_hi, w_hi_nx;
  logic [31:0] r_lo, w_lo_nx;
  logic        r_done, w_done_nx;

  logic [31:0]        w_abs1, w_abs2;
  logic [32:0]        w_shift;
  logic [33:0]        w_diff;
  logic signed [65:0] w_prod;
  logic [31:0]        w_q_fix, w_r_fix;

  assign w_abs1  = bus.req_src1[31] ? (32'd0 - bus.req_src1) : bus.req_src1;
  assign w_abs2  = bus.req_src2[31] ? (32'd0 - bus.req_src2) : bus.req_src2;
  assign w_shift = {r_rem[31:0], r_a[31]};
  assign w_diff  = {1'b0, w_shift} - {1'b0, r_b};
  assign w_prod  = $signed(r_a) * $signed(r_b);
  assign w_q_fix = r_neg_q ? (32'd0 - r_a[31:0])   : r_a[31:0];
  assign w_r_fix = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_rem_nx   = r_rem;
    w_neg_q_nx = r_neg_q;
    w_neg_r_nx = r_neg_r;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_done_nx  = 1'b0;

    if (bus.flush) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_a_nx     = '0;
      w_b_nx     = '0;
      w_rem_nx   = '0;
      w_neg_q_nx = 1'b0;
      w_neg_r_nx = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            case (bus.req_op)
              OP_MULT: begin
                w_a_nx     = {bus.req_src1[31], bus.req_src1};
                w_b_nx     = {bus.req_src2[31], bus.req_src2};
                w_cnt_nx   = 5'(MUL_CYCLES - 1);
                w_state_nx = S_MUL;
              end
              OP_MULTU: begin
                w_a_nx     = {1'b0, bus.req_src1};
                w_b_nx     = {1'b0, bus.req_src2};
                w_cnt_nx   = 5'(MUL_CYCLES - 1);
                w_state_nx = S_MUL;
              end
              OP_DIV: begin
                w_a_nx     = {1'b0, w_abs1};
                w_b_nx     = {1'b0, w_abs2};
                w_rem_nx   = '0;
                w_neg_q_nx = bus.req_src1[31] ^ bus.req_src2[31];
                w_neg_r_nx = bus.req_src1[31];
                w_cnt_nx   = 5'd31;
                w_state_nx = S_DIV;
              end
              OP_DIVU: begin
                w_a_nx     = {1'b0, bus.req_src1};
                w_b_nx     = {1'b0, bus.req_src2};
                w_rem_nx   = '0;
                w_neg_q_nx = 1'b0;
                w_neg_r_nx = 1'b0;
                w_cnt_nx   = 5'd31;
                w_state_nx = S_DIV;
              end
              OP_MTHI: w_hi_nx = bus.req_src1;
              OP_MTLO: w_lo_nx = bus.req_src1;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (r_cnt == 5'd0) begin
            {w_hi_nx, w_lo_nx} = w_prod[63:0];
            w_done_nx  = 1'b1;
            w_state_nx = S_IDLE;
            w_a_nx     = '0;
            w_b_nx     = '0;
          end else begin
            w_cnt_nx = r_cnt - 5'd1;
          end
        end
        S_DIV: begin
          // A zero divisor always "fits", so DIVU x/0 yields all-ones quotient and remainder x.
          w_rem_nx = w_diff[33] ? w_shift : w_diff[32:0];
          w_a_nx   = {1'b0, r_a[30:0], ~w_diff[33]};
          if (r_cnt == 5'd0) begin
            w_state_nx = S_FIX;
          end else begin
            w_cnt_nx = r_cnt - 5'd1;
          end
        end
        S_FIX: begin
          w_lo_nx    = w_q_fix;
          w_hi_nx    = w_r_fix;
          w_done_nx  = 1'b1;
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_a_nx     = '0;
          w_b_nx     = '0;
          w_rem_nx   = '0;
          w_neg_q_nx = 1'b0;
          w_neg_r_nx = 1'b0;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_rem   <= w_rem_nx;
      r_neg_q <= w_neg_q_nx;
      r_neg_r <= w_neg_r_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_done  <= w_done_nx;
    end
  end

  assign bus.req_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;

endmodule
